// File: rtl/noc_output_alloc.sv
// Per-output wormhole allocator: round-robin grant among input heads carrying a header flit,
// then the output is locked to that input until its packet ends, with a registered TX/RTS stage.
module noc_output_alloc #(
    parameter int         NUM_IN      = 5,
    parameter int         IDX_W       = 3,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [2:0] TYPE_HEADER = 3'b001,
    parameter logic [2:0] TYPE_TAIL   = 3'b100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            req,
    input  logic [NUM_IN*DATA_WIDTH-1:0] flit_in,
    input  logic                         dcts,
    output logic [NUM_IN-1:0]            rd_en,
    output logic [DATA_WIDTH-1:0]        tx,
    output logic                         rts,
    output logic                         busy,
    output logic [IDX_W-1:0]             owner,
    output logic                         pkt_err
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rrPtr_q, rrPtr_d;
    logic [11:0]             rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    rts_q, rts_d;
    logic                    pktErr_q, pktErr_d;
    logic                    first_q, first_d;

    logic [2:0]              headType [NUM_IN];
    logic [11:0]             headLen  [NUM_IN];
    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic [11:0]             winnerLen;
    int                      scanIdx;
    logic [DATA_WIDTH-1:0]   ownerFlit;
    logic                    ownerReq;
    logic                    pop;
    logic                    endPkt;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_fields
        assign headType[g] = flit_in[g*DATA_WIDTH + DATA_WIDTH-1 -: 3];
        assign headLen[g]  = flit_in[g*DATA_WIDTH + DATA_WIDTH-4 -: 12];
    end

    // Round-robin scan starting just after the last owner; only header flits may win.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        winnerLen = '0;
        scanIdx   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            scanIdx = int'(rrPtr_q) + k;
            if (scanIdx >= NUM_IN) scanIdx = scanIdx - NUM_IN;
            for (int i = 0; i < NUM_IN; i++) begin
                if (!found && i == scanIdx && req[i] && headType[i] == TYPE_HEADER) begin
                    found     = 1'b1;
                    winner    = IDX_W'(i);
                    winnerLen = headLen[i];
                end
            end
        end
    end

    always_comb begin
        ownerFlit = '0;
        ownerReq  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (owner_q == IDX_W'(i)) begin
                ownerFlit = flit_in[i*DATA_WIDTH +: DATA_WIDTH];
                ownerReq  = req[i];
            end
        end
    end

    // first_q marks that the next pop is the header, so a 0/1-length packet ends cleanly on it.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rrPtr_d  = rrPtr_q;
        rem_d    = rem_q;
        tx_d     = tx_q;
        rts_d    = 1'b0;
        pktErr_d = 1'b0;
        first_d  = first_q;
        rd_en    = '0;
        pop      = 1'b0;
        endPkt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    rem_d   = (winnerLen == 12'd0) ? 12'd0 : winnerLen - 12'd1;
                    first_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                pop = ownerReq && dcts;
                for (int i = 0; i < NUM_IN; i++) begin
                    rd_en[i] = pop && (owner_q == IDX_W'(i));
                end
                if (pop) begin
                    tx_d    = ownerFlit;
                    rts_d   = 1'b1;
                    first_d = 1'b0;
                    if (rem_q == 12'd0) begin
                        endPkt   = 1'b1;
                        pktErr_d = !(ownerFlit[DATA_WIDTH-1 -: 3] == TYPE_TAIL || first_q);
                    end else if (ownerFlit[DATA_WIDTH-1 -: 3] == TYPE_TAIL) begin
                        endPkt   = 1'b1;
                        pktErr_d = 1'b1;
                    end else begin
                        rem_d = rem_q - 12'd1;
                    end
                end
                if (endPkt) begin
                    state_d = IDLE;
                    rrPtr_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rrPtr_q  <= IDX_W'(NUM_IN - 1);
            rem_q    <= '0;
            tx_q     <= '0;
            rts_q    <= 1'b0;
            pktErr_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rrPtr_q  <= rrPtr_d;
            rem_q    <= rem_d;
            tx_q     <= tx_d;
            rts_q    <= rts_d;
            pktErr_q <= pktErr_d;
            first_q  <= first_d;
        end
    end

    assign tx      = tx_q;
    assign rts     = rts_q;
    assign busy    = (state_q == SEND);
    assign owner   = owner_q;
    assign pkt_err = pktErr_q;

endmodule

// File: tb/tb_noc_output_alloc.sv
// Directed bench for noc_output_alloc: a vector table for single-source packets plus hand
// sequences for arbitration order, reset abort and a 3-input header-only instance.
module tb_noc_output_alloc;

    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    localparam logic [31:0] H1  = {HDR,  12'd3, 17'h000A1};
    localparam logic [31:0] B1  = {BODY, 12'd0, 17'h000B1};
    localparam logic [31:0] T1  = {TAIL, 12'd0, 17'h000C1};
    localparam logic [31:0] H3  = {HDR,  12'd4, 17'h000A3};
    localparam logic [31:0] B3A = {BODY, 12'd0, 17'h000B3};
    localparam logic [31:0] B3B = {BODY, 12'd0, 17'h000D3};
    localparam logic [31:0] T3  = {TAIL, 12'd0, 17'h000C3};
    localparam logic [31:0] H4  = {HDR,  12'd4, 17'h000A4};
    localparam logic [31:0] T4  = {TAIL, 12'd0, 17'h000C4};
    localparam logic [31:0] H5  = {HDR,  12'd5, 17'h000A5};
    localparam logic [31:0] B5  = {BODY, 12'd0, 17'h000B5};
    localparam logic [31:0] H5B = {HDR,  12'd2, 17'h001A5};
    localparam logic [31:0] H5C = {HDR,  12'd2, 17'h002A5};
    localparam logic [31:0] T5B = {TAIL, 12'd0, 17'h001C5};
    localparam logic [31:0] H2A = {HDR,  12'd2, 17'h000A2};
    localparam logic [31:0] T2A = {TAIL, 12'd0, 17'h000C2};
    localparam logic [31:0] H2B = {HDR,  12'd2, 17'h001A2};
    localparam logic [31:0] T2B = {TAIL, 12'd0, 17'h001C2};
    localparam logic [31:0] H2C = {HDR,  12'd2, 17'h002A2};
    localparam logic [31:0] T2C = {TAIL, 12'd0, 17'h002C2};
    localparam logic [31:0] H6  = {HDR,  12'd1, 17'h000A6};
    localparam logic [31:0] B6  = {BODY, 12'd0, 17'h000B6};

    typedef struct {
        string       tag;
        logic        rst;
        logic [4:0]  req;
        logic        dcts;
        logic [2:0]  src;
        logic [31:0] flit;
        logic [4:0]  expRdEn;
        logic        expRts;
        logic [31:0] expTx;
        logic        expBusy;
        logic [2:0]  expOwner;
        logic        expErr;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [4:0]   req;
    logic [159:0] flitIn;
    logic         dcts;
    logic [4:0]   rdEn;
    logic [31:0]  tx;
    logic         rts;
    logic         busy;
    logic [2:0]   owner;
    logic         pktErr;

    logic [2:0]   req3;
    logic [95:0]  flitIn3;
    logic         dcts3;
    logic [2:0]   rdEn3;
    logic [31:0]  tx3;
    logic         rts3;
    logic         busy3;
    logic [1:0]   owner3;
    logic         pktErr3;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    noc_output_alloc #(.NUM_IN(5), .IDX_W(3), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_in(flitIn), .dcts(dcts),
        .rd_en(rdEn), .tx(tx), .rts(rts), .busy(busy), .owner(owner), .pkt_err(pktErr)
    );

    noc_output_alloc #(.NUM_IN(3), .IDX_W(2), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .flit_in(flitIn3), .dcts(dcts3),
        .rd_en(rdEn3), .tx(tx3), .rts(rts3), .busy(busy3), .owner(owner3), .pkt_err(pktErr3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [159:0] place(input logic [2:0] src, input logic [31:0] f);
        logic [159:0] r;
        r = '0;
        r[int'(src)*32 +: 32] = f;
        return r;
    endfunction

    function automatic vec_t mkVec(input string tag, input logic rstV, input logic [4:0] reqV,
                                   input logic dctsV, input logic [2:0] src, input logic [31:0] f,
                                   input logic [4:0] rd, input logic rtsE, input logic [31:0] txE,
                                   input logic busyE, input logic [2:0] ownE, input logic errE);
        vec_t v;
        v.tag = tag; v.rst = rstV; v.req = reqV; v.dcts = dctsV; v.src = src; v.flit = f;
        v.expRdEn = rd; v.expRts = rtsE; v.expTx = txE; v.expBusy = busyE;
        v.expOwner = ownE; v.expErr = errE;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check the combinational pop strobe,
    // then advance just past the next rising edge so registered outputs can be checked.
    task automatic applyStimulus(input logic rstV, input logic [4:0] reqV, input logic dctsV,
                                 input logic [159:0] flitsV, input logic [4:0] expRdEn,
                                 input string name);
        @(negedge clk);
        rst = rstV; req = reqV; dcts = dctsV; flitIn = flitsV;
        #1;
        checkOutput({name, " rd_en"}, 32'(rdEn), 32'(expRdEn));
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs(input string name, input logic expRts, input logic [31:0] expTx,
                             input logic expBusy, input logic [2:0] expOwner, input logic expErr);
        checkOutput({name, " rts"},     32'(rts),    32'(expRts));
        checkOutput({name, " tx"},      tx,          expTx);
        checkOutput({name, " busy"},    32'(busy),   32'(expBusy));
        checkOutput({name, " owner"},   32'(owner),  32'(expOwner));
        checkOutput({name, " pkt_err"}, 32'(pktErr), 32'(expErr));
    endtask

    task automatic applyStimulus3(input logic [2:0] reqV, input logic [95:0] flitsV,
                                  input logic [2:0] expRdEn, input string name);
        @(negedge clk);
        req3 = reqV; flitIn3 = flitsV;
        #1;
        checkOutput({name, " rd_en"}, 32'(rdEn3), 32'(expRdEn));
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegs3(input string name, input logic expRts, input logic [31:0] expTx,
                              input logic expBusy, input logic [1:0] expOwner, input logic expErr);
        checkOutput({name, " rts"},     32'(rts3),    32'(expRts));
        checkOutput({name, " tx"},      tx3,          expTx);
        checkOutput({name, " busy"},    32'(busy3),   32'(expBusy));
        checkOutput({name, " owner"},   32'(owner3),  32'(expOwner));
        checkOutput({name, " pkt_err"}, 32'(pktErr3), 32'(expErr));
    endtask

    initial begin
        rst = 1'b0; req = '0; dcts = 1'b1; flitIn = '0;
        req3 = '0; flitIn3 = '0; dcts3 = 1'b1;
        repeat (2) @(posedge clk);

        vecs.push_back(mkVec("reset a",  1'b0, 5'b00000, 1'b1, 3'd0, 32'h0, 5'b00000, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mkVec("reset b",  1'b0, 5'b00000, 1'b1, 3'd0, 32'h0, 5'b00000, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0));
        vecs.push_back(mkVec("T1 arb",   1'b1, 5'b00100, 1'b1, 3'd2, H1,    5'b00000, 1'b0, 32'h0, 1'b1, 3'd2, 1'b0));
        vecs.push_back(mkVec("T1 hdr",   1'b1, 5'b00100, 1'b1, 3'd2, H1,    5'b00100, 1'b1, H1,    1'b1, 3'd2, 1'b0));
        vecs.push_back(mkVec("T1 body",  1'b1, 5'b00100, 1'b1, 3'd2, B1,    5'b00100, 1'b1, B1,    1'b1, 3'd2, 1'b0));
        vecs.push_back(mkVec("T1 tail",  1'b1, 5'b00100, 1'b1, 3'd2, T1,    5'b00100, 1'b1, T1,    1'b0, 3'd2, 1'b0));
        vecs.push_back(mkVec("T1 idle",  1'b1, 5'b00000, 1'b1, 3'd0, 32'h0, 5'b00000, 1'b0, T1,    1'b0, 3'd2, 1'b0));
        vecs.push_back(mkVec("T3 arb",   1'b1, 5'b00010, 1'b1, 3'd1, H3,    5'b00000, 1'b0, T1,    1'b1, 3'd1, 1'b0));
        vecs.push_back(mkVec("T3 f1",    1'b1, 5'b00010, 1'b1, 3'd1, H3,    5'b00010, 1'b1, H3,    1'b1, 3'd1, 1'b0));
        vecs.push_back(mkVec("T3 f2",    1'b1, 5'b00010, 1'b1, 3'd1, B3A,   5'b00010, 1'b1, B3A,   1'b1, 3'd1, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec("T3 stall", 1'b1, 5'b00010, 1'b0, 3'd1, B3B, 5'b00000, 1'b0, B3A, 1'b1, 3'd1, 1'b0));
        vecs.push_back(mkVec("T3 f3",    1'b1, 5'b00010, 1'b1, 3'd1, B3B,   5'b00010, 1'b1, B3B,   1'b1, 3'd1, 1'b0));
        vecs.push_back(mkVec("T3 f4",    1'b1, 5'b00010, 1'b1, 3'd1, T3,    5'b00010, 1'b1, T3,    1'b0, 3'd1, 1'b0));
        vecs.push_back(mkVec("T4 arb",   1'b1, 5'b01000, 1'b1, 3'd3, H4,    5'b00000, 1'b0, T3,    1'b1, 3'd3, 1'b0));
        vecs.push_back(mkVec("T4 hdr",   1'b1, 5'b01000, 1'b1, 3'd3, H4,    5'b01000, 1'b1, H4,    1'b1, 3'd3, 1'b0));
        vecs.push_back(mkVec("T4 early", 1'b1, 5'b01000, 1'b1, 3'd3, T4,    5'b01000, 1'b1, T4,    1'b0, 3'd3, 1'b1));
        vecs.push_back(mkVec("T4 idle",  1'b1, 5'b00000, 1'b1, 3'd0, 32'h0, 5'b00000, 1'b0, T4,    1'b0, 3'd3, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].dcts, place(vecs[i].src, vecs[i].flit),
                          vecs[i].expRdEn, vecs[i].tag);
            checkRegs(vecs[i].tag, vecs[i].expRts, vecs[i].expTx, vecs[i].expBusy,
                      vecs[i].expOwner, vecs[i].expErr);
        end

        // T5: abort an L=5 packet on in4 after its 2nd flit; rr pointer must restart at NUM_IN-1,
        // so with headers on in1 and in4 the scan 0,1,.. picks in1.
        applyStimulus(1'b1, 5'b10000, 1'b1, place(3'd4, H5), 5'b00000, "T5 arb");
        checkRegs("T5 arb", 1'b0, T4, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10000, 1'b1, place(3'd4, H5), 5'b10000, "T5 f1");
        checkRegs("T5 f1", 1'b1, H5, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10000, 1'b1, place(3'd4, B5), 5'b10000, "T5 f2");
        checkRegs("T5 f2", 1'b1, B5, 1'b1, 3'd4, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1, '0, 5'b00000, "T5 rst");
        checkRegs("T5 rst", 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10010, 1'b1, place(3'd1, H5B) | place(3'd4, H5C), 5'b00000, "T5 regrant");
        checkRegs("T5 regrant", 1'b0, 32'h0, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00010, 1'b1, place(3'd1, H5B), 5'b00010, "T5 hdr");
        checkRegs("T5 hdr", 1'b1, H5B, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00010, 1'b1, place(3'd1, T5B), 5'b00010, "T5 tail");
        checkRegs("T5 tail", 1'b1, T5B, 1'b0, 3'd1, 1'b0);

        // T2: fresh reset, simultaneous headers on in0 and in3 with in0 re-requesting.
        applyStimulus(1'b0, 5'b00000, 1'b1, '0, 5'b00000, "T2 rst");
        checkRegs("T2 rst", 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, H2A) | place(3'd3, H2B), 5'b00000, "T2 arb0");
        checkRegs("T2 arb0", 1'b0, 32'h0, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, H2A) | place(3'd3, H2B), 5'b00001, "T2 in0 hdr");
        checkRegs("T2 in0 hdr", 1'b1, H2A, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, T2A) | place(3'd3, H2B), 5'b00001, "T2 in0 tail");
        checkRegs("T2 in0 tail", 1'b1, T2A, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, H2C) | place(3'd3, H2B), 5'b00000, "T2 arb3");
        checkRegs("T2 arb3", 1'b0, T2A, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, H2C) | place(3'd3, H2B), 5'b01000, "T2 in3 hdr");
        checkRegs("T2 in3 hdr", 1'b1, H2B, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b01001, 1'b1, place(3'd0, H2C) | place(3'd3, T2B), 5'b01000, "T2 in3 tail");
        checkRegs("T2 in3 tail", 1'b1, T2B, 1'b0, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b00001, 1'b1, place(3'd0, H2C), 5'b00000, "T2 arb0 again");
        checkRegs("T2 arb0 again", 1'b0, T2B, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00001, 1'b1, place(3'd0, H2C), 5'b00001, "T2 in0 hdr2");
        checkRegs("T2 in0 hdr2", 1'b1, H2C, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00001, 1'b1, place(3'd0, T2C), 5'b00001, "T2 in0 tail2");
        checkRegs("T2 in0 tail2", 1'b1, T2C, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000, 1'b1, '0, 5'b00000, "T2 idle");
        checkRegs("T2 idle", 1'b0, T2C, 1'b0, 3'd0, 1'b0);

        // T6: 3-input instance; header-only packet on in1 while a stray body flit sits at in0.
        applyStimulus3(3'b011, {32'h0, H6, B6}, 3'b000, "T6 arb");
        checkRegs3("T6 arb", 1'b0, 32'h0, 1'b1, 2'd1, 1'b0);
        applyStimulus3(3'b011, {32'h0, H6, B6}, 3'b010, "T6 pop");
        checkRegs3("T6 pop", 1'b1, H6, 1'b0, 2'd1, 1'b0);
        applyStimulus3(3'b001, {32'h0, 32'h0, B6}, 3'b000, "T6 body a");
        checkRegs3("T6 body a", 1'b0, H6, 1'b0, 2'd1, 1'b0);
        applyStimulus3(3'b001, {32'h0, 32'h0, B6}, 3'b000, "T6 body b");
        checkRegs3("T6 body b", 1'b0, H6, 1'b0, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
